// File: rtl/r5fp_isqrt_pkg.sv
// r5fp_isqrt_pkg: state encoding and counter-width helper for the sequential integer square root.
package r5fp_isqrt_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/r5fp_isqrt_step.sv
// r5fp_isqrt_step: one restoring square-root iteration, producing one root bit.
module r5fp_isqrt_step #(
  parameter int W = 14
) (
  input  logic [W:0]   r,
  input  logic [W-1:0] q,
  input  logic [1:0]   bits,
  output logic [W:0]   r_nxt,
  output logic [W-1:0] q_nxt
);
  logic [W+2:0] t;
  logic [W+2:0] trial;
  logic         ge;
  // r[W] is zero whenever a step is taken, so widening t keeps the result exact
  assign t     = {r, bits};
  assign trial = {1'b0, q, 2'b01};
  assign ge    = t >= trial;
  assign r_nxt = (W+1)'(ge ? t - trial : t);
  assign q_nxt = {q[W-2:0], ge};
endmodule

// File: rtl/r5fp_int_sqrt_seq.sv
// r5fp_int_sqrt_seq: iterative floor(sqrt({D,W'b0})) with remainder, one root bit per cycle.
// Optional R5FP_ISQRT_ZERO_BYPASS_EN: a zero radicand completes in a single edge.
module r5fp_int_sqrt_seq
  import r5fp_isqrt_pkg::*;
#(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] D_i,
  input  logic         strobe_i,
  output logic [W-1:0] Quo_o,
  output logic [W:0]   Rem_o,
  output logic         done_o,
  output logic         ready_o
);
  localparam int CW = clog2(W);
  state_t         state, state_nxt;
  logic [2*W-1:0] rad;
  logic [W-1:0]   q, q_nxt;
  logic [W:0]     r, r_nxt;
  logic [CW-1:0]  cnt;
  logic           accept, last, zero_byp;
  assign ready_o = state != BUSY;
  assign done_o  = state == DONE;
  assign accept  = ready_o && strobe_i;
  assign last    = cnt == '0;
`ifdef R5FP_ISQRT_ZERO_BYPASS_EN
  assign zero_byp = D_i == '0;
`else
  assign zero_byp = 1'b0;
`endif
  r5fp_isqrt_step #(.W(W)) u_step (
    .r     (r),
    .q     (q),
    .bits  (rad[2*W-1 -: 2]),
    .r_nxt (r_nxt),
    .q_nxt (q_nxt)
  );
  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = zero_byp ? DONE : BUSY;
    else if (state == DONE) state_nxt = IDLE;
    else if (state == BUSY && last) state_nxt = DONE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rad   <= '0;
      q     <= '0;
      r     <= '0;
      cnt   <= '0;
      Quo_o <= '0;
      Rem_o <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rad <= {D_i, {W{1'b0}}};
        q   <= '0;
        r   <= '0;
        cnt <= CW'(W - 1);
        if (zero_byp) begin
          Quo_o <= '0;
          Rem_o <= '0;
        end
      end else if (state == BUSY) begin
        rad <= rad << 2;
        q   <= q_nxt;
        r   <= r_nxt;
        if (!last) cnt <= cnt - CW'(1);
        if (last) begin
          Quo_o <= q_nxt;
          Rem_o <= r_nxt;
        end
      end
    end
  end
  w_even: assert property (@(posedge clk) (W % 2) == 0);
endmodule

// File: tb/tb_r5fp_int_sqrt_seq.sv
// tb_r5fp_int_sqrt_seq: scoreboard bench for W=4 and W=14 instances against an arithmetic sqrt model.
module tb_r5fp_int_sqrt_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst4, rst14, stb4, stb14, done4, done14, rdy4, rdy14;
  logic [3:0]  d4, quo4;
  logic [4:0]  rem4;
  logic [13:0] d14, quo14;
  logic [14:0] rem14;
  typedef struct {
    longint quo;
    longint rem;
    int     due;
  } exp_t;
  exp_t sb0[$], sb1[$];
  exp_t m0, m1;
  int cyc = 0, n_tests = 0, n_fail = 0;
  r5fp_int_sqrt_seq #(.W(4)) dut4 (
    .clk(clk), .reset(rst4), .D_i(d4), .strobe_i(stb4),
    .Quo_o(quo4), .Rem_o(rem4), .done_o(done4), .ready_o(rdy4)
  );
  r5fp_int_sqrt_seq #(.W(14)) dut14 (
    .clk(clk), .reset(rst14), .D_i(d14), .strobe_i(stb14),
    .Quo_o(quo14), .Rem_o(rem14), .done_o(done14), .ready_o(rdy14)
  );
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction
  function automatic void ref_sqrt(input int w, input longint d, output longint q, output longint r);
    longint n, lo, hi, mid;
    n  = d << w;
    lo = 0;
    hi = (longint'(1) << w) - 1;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= n) lo = mid;
      else hi = mid - 1;
    end
    q = lo;
    r = n - lo * lo;
  endfunction
  always @(negedge clk) if (!rst4) begin
    if (sb0.size() > 0 && sb0[0].due < cyc) begin
      chk("timeout4", cyc, sb0[0].due);
      void'(sb0.pop_front());
    end
    if (done4) begin
      if (sb0.size() == 0) chk("spurious_done4", done4, 0);
      else begin
        m0 = sb0.pop_front();
        chk("quo4", quo4, m0.quo);
        chk("rem4", rem4, m0.rem);
        chk("latency4", cyc, m0.due);
      end
    end
  end
  always @(negedge clk) if (!rst14) begin
    if (sb1.size() > 0 && sb1[0].due < cyc) begin
      chk("timeout14", cyc, sb1[0].due);
      void'(sb1.pop_front());
    end
    if (done14) begin
      if (sb1.size() == 0) chk("spurious_done14", done14, 0);
      else begin
        m1 = sb1.pop_front();
        chk("quo14", quo14, m1.quo);
        chk("rem14", rem14, m1.rem);
        chk("latency14", cyc, m1.due);
      end
    end
  end
  task automatic set_in(input int u, input logic s, input logic [13:0] d);
    if (u == 0) begin
      stb4 = s;
      d4   = d[3:0];
    end else begin
      stb14 = s;
      d14   = d;
    end
  endtask
  // called at a negedge where the unit is ready; returns at the negedge of the done cycle
  task automatic run_op(input int u, input logic [13:0] d, input bit g);
    int w, lat;
    longint eq, er;
    exp_t e;
    logic [13:0] dd;
    w   = (u == 0) ? 4 : 14;
    dd  = (u == 0) ? (d & 14'hf) : d;
    lat = w;
`ifdef R5FP_ISQRT_ZERO_BYPASS_EN
    if (dd == 0) lat = 0;
`endif
    ref_sqrt(w, longint'(dd), eq, er);
    set_in(u, 1'b1, dd);
    chk("ready_at_strobe", (u == 0) ? rdy4 : rdy14, 1);
    e.quo = eq;
    e.rem = er;
    e.due = cyc + lat + 1;
    if (u == 0) sb0.push_back(e);
    else sb1.push_back(e);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk("ready_busy", (u == 0) ? rdy4 : rdy14, 0);
      set_in(u, g, 14'($urandom));
    end
    set_in(u, 1'b0, 14'($urandom));
    @(negedge clk);
  endtask
  initial begin
    rst4 = 1'b0; rst14 = 1'b0;
    stb4 = 1'b0; stb14 = 1'b0;
    d4 = '0; d14 = '0;
    #1;
    rst4 = 1'b1; rst14 = 1'b1;
    stb4 = 1'b1; stb14 = 1'b1;
    d4 = 4'd7; d14 = 14'h123;
    #2;
    chk("rst_ready4", rdy4, 1);
    chk("rst_done4", done4, 0);
    chk("rst_quo4", quo4, 0);
    chk("rst_rem4", rem4, 0);
    #14;
    chk("rst_ready14", rdy14, 1);
    chk("rst_done14", done14, 0);
    chk("rst_quo14", quo14, 0);
    chk("rst_rem14", rem14, 0);
    @(negedge clk);
    rst4 = 1'b0; rst14 = 1'b0;
    stb4 = 1'b0; stb14 = 1'b0;
    repeat (2) @(negedge clk);
    run_op(0, 14'd4, 1'b0);
    repeat (2) @(negedge clk);
    for (int d = 0; d < 16; d++) run_op(0, 14'(d), 1'b0);
    repeat (2) @(negedge clk);
    run_op(1, 14'h2000, 1'b0);
    repeat (2) @(negedge clk);
    run_op(1, 14'h0, 1'b0);
    run_op(1, 14'h1a5c, 1'b1);
    for (int i = 0; i < 25; i++) begin
      logic [13:0] d;
      d = 14'($urandom);
      if (i % 7 == 0) d = 14'h0;
      if (i % 11 == 3) d = 14'h3fff;
      run_op(1, d, 1'($urandom % 2));
      if ($urandom % 3 == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    set_in(1, 1'b1, 14'h1234);
    @(negedge clk);
    set_in(1, 1'b0, 14'h0);
    repeat (3) @(negedge clk);
    #2 rst14 = 1'b1;
    #1;
    chk("abort_ready14", rdy14, 1);
    chk("abort_done14", done14, 0);
    chk("abort_quo14", quo14, 0);
    chk("abort_rem14", rem14, 0);
    repeat (2) @(negedge clk);
    rst14 = 1'b0;
    repeat (18) @(negedge clk);
    run_op(1, 14'h2b7, 1'b0);
    repeat (20) @(negedge clk);
    chk("sb_drained", sb0.size() + sb1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/r5fp_int_sqrt_seq.md
Name: r5fp_int_sqrt_seq

Overview:
- Responder end of the integer square-root handshake (D / strobe / Quo / Rem / done / ready) that the floating-point sqrt core drives to obtain the extended significand root.
- Iterative restoring digit-by-digit engine producing one root bit per cycle.
- Dedicated sqrt-only alternative to the shared divide/sqrt engine: smaller and with fixed latency.
- Sits beside the FP sqrt controller inside the sqrt wrapper; no FP knowledge (no exponent, rounding or NaN handling).

Parameters:
- W, 14, operand and root width; equals the extended significand width (SIG_W+3 or SIG_W+4, always even); legal range W >= 4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- D_i  input  W  radicand high half; the effective radicand is {D_i, W'b0} (2W bits).
- strobe_i  input  1  start request; accepted only while ready_o=1.
- Quo_o  output  W  floor(sqrt({D,W'b0})).
- Rem_o  output  W+1  {D,W'b0} - Quo_o^2, always <= 2*Quo_o; the consumer uses |Rem_o as sticky.
- done_o  output  1  one-cycle pulse; Quo_o and Rem_o are valid.
- ready_o  output  1  engine can accept strobe_i this cycle.

Behaviour:
- Reset (async, asserted): state=IDLE; ready_o=1, done_o=0, Quo_o=0, Rem_o=0; iteration counter=0. A strobe_i high during reset is ignored.
- States: IDLE, BUSY, DONE.
- IDLE, strobe_i=1 at edge k:
  - latch radicand shift register R={D_i,W'b0}, partial root q=0, partial remainder r=0 (W+2 bits), counter=W-1.
  - go to BUSY; ready_o=0.
- BUSY, each edge performs one step:
  - t={r[W-1:0],R[2W-1:2W-2]}; R<<=2; trial={q,2'b01}.
  - if t>=trial: r=t-trial, q={q[W-2:0],1'b1}; else r=t, q={q[W-2:0],1'b0}.
  - at counter==0 go to DONE, else decrement counter.
  - All comparisons are unsigned at W+2 bits; r never exceeds W+1 significant bits.
- Timing: strobe at edge k gives steps at edges k+1..k+W. The step at edge k+W loads Quo_o=q and Rem_o=r[W:0] and enters DONE. done_o=1 and ready_o=1 in the cycle after edge k+W. Latency is W+1 edges from strobe to done.
- DONE (one cycle): done_o=1, ready_o=1.
  - strobe_i=1 is accepted (back-to-back) and goes to BUSY.
  - otherwise go to IDLE.
  - done_o drops after exactly one cycle in both cases.
- Quo_o and Rem_o hold their last result until the next result load. They are not cleared on strobe.
- strobe_i while BUSY: ignored; no effect on the current operation, no error flag.
- D_i is sampled only at the accepting edge; later changes have no effect.
- D_i=0: full W-cycle run; Quo_o=0, Rem_o=0.
- Reset mid-operation: immediate abort to the reset values; no done_o is issued for the aborted operation.

Optional Feature:
- Macro R5FP_ISQRT_ZERO_BYPASS_EN.
- Defined:
  - strobe accepted with D_i==0 skips BUSY: goes directly to DONE, loads Quo_o=0 and Rem_o=0, done_o one cycle later (latency 1).
  - nonzero D_i is unchanged.
- Undefined: all operations take W+1 edges; no zero detector is instantiated.

Decomposition:
- Package r5fp_isqrt_pkg: state enum (IDLE, BUSY, DONE), counter-width function clog2(W).
- Sub-module r5fp_isqrt_step: purely combinational single iteration.
  - Inputs: r, q, two radicand bits.
  - Outputs: next r, next q.
  - Parameterised by W so a future radix-4 version can instantiate two in series.
- A W-is-even check is a simulation-only assertion in the top.

Test Plan:
- W=4, D=4'b0100 (radicand 64), strobe one cycle -> done_o exactly 5 edges later; Quo=8, Rem=0; ready_o=0 for the 4 BUSY cycles.
- W=4, exhaustive D=0..15, back-to-back strobes in each DONE cycle:
  - D=15 -> Quo=15, Rem=15; D=2 -> Quo=5, Rem=7; D=9 -> Quo=12, Rem=0.
  - No idle cycle between operations.
- W=14, D=14'h2000 (radicand 2^27) -> Quo=11585, Rem=5503; done_o width exactly 1 cycle.
- Strobe re-asserted with a different D during BUSY -> ignored; original result returned at the original latency.
- Reset asserted asynchronously mid-BUSY (between edges) -> ready_o=1, done_o=0, Quo=0, Rem=0 immediately; no done pulse afterwards; a new strobe works normally.
- D=0:
  - with R5FP_ISQRT_ZERO_BYPASS_EN: done_o after 1 edge, Quo=0, Rem=0.
  - without it: done_o after W+1 edges, same values.
